// File: rtl/rate_threshold_monitor_pkg.sv
// rate_threshold_monitor_pkg: shared state encoding and default sizing for the rate threshold monitor
package rate_threshold_monitor_pkg;
  localparam int DEF_WIDTH = 25;
  localparam int DEF_HOLDOFF = 3;
  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_HIGH   = 2'd1,
    ST_LOW    = 2'd2
  } state_e;
endpackage

// File: rtl/rate_holdoff_fsm.sv
// rate_holdoff_fsm: hysteresis FSM with holdoff run counter driving registered alarm decodes
module rate_holdoff_fsm
  import rate_threshold_monitor_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HOLDOFF = DEF_HOLDOFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] thresh_hi_i,
  input  logic [WIDTH-1:0] thresh_lo_i,
  output logic             alarm_hi_o,
  output logic             alarm_lo_o
);
  localparam int RW = $clog2(HOLDOFF + 1);
  localparam logic [RW-1:0] HOLD = RW'(HOLDOFF);
  state_e state_q, state_d;
  logic [RW-1:0] run_q, run_d, run_inc;
  logic above_q, above_d, alarm_hi_q, alarm_lo_q;
  logic above, below;
  assign above   = count_i > thresh_hi_i;
  assign below   = count_i < thresh_lo_i;
  assign run_inc = (run_q == HOLD) ? run_q : run_q + 1'b1;
  // next state: a run of HOLDOFF qualifying counts moves the state; run restarts on condition change
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    above_d = above_q;
    if (clear_i) begin
      state_d = ST_NORMAL;
      run_d   = '0;
    end else if (valid_i) begin
      case (state_q)
        ST_NORMAL: begin
          if (above || below) begin
            run_d   = (run_q != '0 && above_q == above) ? run_inc : RW'(1);
            above_d = above;
            if (run_d == HOLD) begin
              state_d = above ? ST_HIGH : ST_LOW;
              run_d   = '0;
            end
          end else begin
            run_d = '0;
          end
        end
        ST_HIGH: begin
          run_d = above ? '0 : run_inc;
          if (run_d == HOLD) begin
            state_d = ST_NORMAL;
            run_d   = '0;
          end
        end
        ST_LOW: begin
          run_d = below ? '0 : run_inc;
          if (run_d == HOLD) begin
            state_d = ST_NORMAL;
            run_d   = '0;
          end
        end
        default: begin
          state_d = ST_NORMAL;
          run_d   = '0;
        end
      endcase
    end
  end
  // state, run counter and alarm decodes (alarms lag the state by one cycle)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_NORMAL;
      run_q      <= '0;
      above_q    <= 1'b0;
      alarm_hi_q <= 1'b0;
      alarm_lo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      above_q    <= above_d;
      alarm_hi_q <= state_q == ST_HIGH;
      alarm_lo_q <= state_q == ST_LOW;
    end
  end
  assign alarm_hi_o = alarm_hi_q;
  assign alarm_lo_o = alarm_lo_q;
endmodule

// File: rtl/rate_threshold_monitor.sv
// rate_threshold_monitor: captures interval counts for readout and flags sustained high/low rates
module rate_threshold_monitor
  import rate_threshold_monitor_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HOLDOFF = DEF_HOLDOFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_valid_in,
  input  logic [WIDTH-1:0] thresh_hi_in,
  input  logic [WIDTH-1:0] thresh_lo_in,
  input  logic             thresh_load,
  input  logic             rd_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_overrun,
  output logic             alarm_hi,
  output logic             alarm_lo
);
  logic [WIDTH-1:0] capture_q, capture_d, rd_data_q, rd_data_d;
  logic [WIDTH-1:0] thr_hi_q, thr_lo_q;
  logic pending_q, pending_d, overrun_q, overrun_d;
  logic rd_valid_q, rd_overrun_q, rd_overrun_d;
  // capture/readout next state; a read in the same cycle as a new count returns the old capture
  always_comb begin
    capture_d    = count_valid_in ? count_in : capture_q;
    pending_d    = count_valid_in | (pending_q & ~rd_req);
    overrun_d    = ~rd_req & (overrun_q | (count_valid_in & pending_q));
    rd_data_d    = rd_req ? capture_q : rd_data_q;
    rd_overrun_d = rd_req ? overrun_q : rd_overrun_q;
  end
  // capture, readout and threshold shadow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      capture_q    <= '0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_overrun_q <= 1'b0;
      thr_hi_q     <= '1;
      thr_lo_q     <= '0;
    end else begin
      capture_q    <= capture_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_req;
      rd_overrun_q <= rd_overrun_d;
      thr_hi_q     <= thresh_load ? thresh_hi_in : thr_hi_q;
      thr_lo_q     <= thresh_load ? thresh_lo_in : thr_lo_q;
    end
  end
  rate_holdoff_fsm #(.WIDTH(WIDTH), .HOLDOFF(HOLDOFF)) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (count_valid_in & ~thresh_load),
    .clear_i     (thresh_load),
    .count_i     (count_in),
    .thresh_hi_i (thr_hi_q),
    .thresh_lo_i (thr_lo_q),
    .alarm_hi_o  (alarm_hi),
    .alarm_lo_o  (alarm_lo)
  );
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign rd_overrun = rd_overrun_q;
endmodule
